// File: rtl/abus_disp_pkg.sv
// Shared types and constants for the abus single-digit hex display.
// Latency: n/a (declarations only).
// Backpressure: n/a; the display has no handshake and is only paused via hold.
package abus_disp_pkg;

    // Display sequencing phases; one full period is
    // CAPTURE -> SHOW_HI -> GAP1 -> SHOW_LO -> GAP2 -> CAPTURE.
    typedef enum logic [2:0] {
        ST_CAPTURE = 3'd0,
        ST_SHOW_HI = 3'd1,
        ST_GAP1    = 3'd2,
        ST_SHOW_LO = 3'd3,
        ST_GAP2    = 3'd4
    } disp_state_e;

    // All segments dark (active-high encoding, bit0 = a .. bit6 = g).
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex digit glyphs, indexed by nibble value. Packed with entry 15 first,
    // so SEG_HEX[n] is the glyph for digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Larger of two integers, used to size the dwell counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/abus_hex_display_hex_to_seg7.sv
// Nibble to 7-segment glyph decoder (active-high segments, bit0 = a).
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module hex_to_seg7
    import abus_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup; every nibble value has a defined glyph.
    always_comb begin
        seg_o = SEG_HEX[nib_i];
    end

endmodule

// File: rtl/abus_hex_display.sv
// Shows a snapshot of abus on one 7-segment digit: high nibble (dp lit), gap, low nibble, gap.
// Latency: 1 CAPTURE cycle, then SHOW_CYCLES/GAP_CYCLES dwell per phase; outputs decode registered state only.
// Backpressure: hold freezes state, counter, snapshot and outputs. Build option: SEG_ACTIVE_LOW_EN inverts seg/dp.
module abus_hex_display
    import abus_disp_pkg::*;
#(
    parameter int SHOW_CYCLES = 10_000_000,
    parameter int GAP_CYCLES  = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] abus_in,
    input  logic       hold,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic       nibble_sel
);

    // Derived counter width; wide enough to hold the longest dwell value.
    localparam int CNT_W = $clog2(max_int(SHOW_CYCLES, GAP_CYCLES) + 1);

    // Terminal counts for each dwell phase. With no gap configured the gap
    // states are never entered, so GAP_LAST is never compared.
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

    disp_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       snap_q,  snap_d;

    logic [3:0]       nib_sel;
    logic [6:0]       seg_glyph;
    logic [6:0]       seg_raw;
    logic             dp_raw;
    logic             show_hi;
    logic             show_lo;

    // State, dwell counter and snapshot registers; reset wins over hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CAPTURE;
            cnt_q   <= '0;
            snap_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state logic: each dwell phase counts 0..N-1 and then moves on with
    // the counter cleared. While hold is high nothing advances at all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;

        if (!hold) begin
            unique case (state_q)
                ST_CAPTURE: begin
                    snap_d  = abus_in;
                    cnt_d   = '0;
                    state_d = ST_SHOW_HI;
                end

                ST_SHOW_HI: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (HAS_GAP) begin
                            state_d = ST_GAP1;
                        end else begin
                            state_d = ST_SHOW_LO;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_GAP1: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW_LO;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_SHOW_LO: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (HAS_GAP) begin
                            state_d = ST_GAP2;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_GAP2: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_CAPTURE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    // Unreachable encodings recover to a clean period start.
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end
            endcase
        end
    end

    // Select which snapshot nibble feeds the decoder; only matters while showing.
    always_comb begin
        show_hi = (state_q == ST_SHOW_HI);
        show_lo = (state_q == ST_SHOW_LO);
        nib_sel = show_hi ? snap_q[7:4] : snap_q[3:0];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nib_i (nib_sel),
        .seg_o (seg_glyph)
    );

    // Active-high display image from registered state: glyph while showing,
    // dark otherwise; dp marks the high nibble.
    always_comb begin
        seg_raw = SEG_BLANK;
        dp_raw  = 1'b0;
        if (show_hi || show_lo) begin
            seg_raw = seg_glyph;
        end
        if (show_hi) begin
            dp_raw = 1'b1;
        end
    end

    // Output polarity; common-anode boards need segments and dp inverted,
    // nibble_sel stays a plain debug flag in both builds.
`ifdef SEG_ACTIVE_LOW_EN
    always_comb begin
        seg_out    = ~seg_raw;
        dp_out     = ~dp_raw;
        nibble_sel = show_hi;
    end
`else
    always_comb begin
        seg_out    = seg_raw;
        dp_out     = dp_raw;
        nibble_sel = show_hi;
    end
`endif

endmodule

// File: tb/tb_abus_hex_display.sv
// Bench for abus_hex_display: table vectors, hand-written corner sequences and random stimulus vs a position-based model.
// Two instances share the inputs: one with a 2-cycle gap, one with no gap.
// Expected values are built active-high and inverted when SEG_ACTIVE_LOW_EN is defined.
module tb_abus_hex_display;

    localparam int S  = 4;
    localparam int G  = 2;
    localparam int G0 = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic [7:0] abus;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, ns_a, ns_b;

    always #5 clk = ~clk;

    abus_hex_display #(.SHOW_CYCLES(S), .GAP_CYCLES(G)) dut_a (
        .clk(clk), .rst(rst), .abus_in(abus), .hold(hold),
        .seg_out(seg_a), .dp_out(dp_a), .nibble_sel(ns_a)
    );

    abus_hex_display #(.SHOW_CYCLES(S), .GAP_CYCLES(G0)) dut_b (
        .clk(clk), .rst(rst), .abus_in(abus), .hold(hold),
        .seg_out(seg_b), .dp_out(dp_b), .nibble_sel(ns_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [6:0] dec_tbl [16];

    // Reference model: position within the display period plus the snapshot.
    int         p_a, p_b;
    logic [7:0] snap_a, snap_b;

    typedef struct {
        logic       r;
        logic       h;
        logic [7:0] a;
        logic [8:0] exp;   // {nibble_sel, dp, seg} active-high
    } vec_t;

    vec_t tv [16];

    function automatic logic [8:0] pol(input logic [8:0] v);
`ifdef SEG_ACTIVE_LOW_EN
        return {v[8], ~v[7:0]};
`else
        return v;
`endif
    endfunction

    function automatic logic [8:0] model_out(input int p, input logic [7:0] s, input int g);
        if (p >= 1 && p <= S)
            return pol({1'b1, 1'b1, dec_tbl[s[7:4]]});
        if (p >= S + g + 1 && p <= 2 * S + g)
            return pol({1'b0, 1'b0, dec_tbl[s[3:0]]});
        return pol(9'h000);
    endfunction

    function automatic vec_t row(input logic r, input logic h, input logic [7:0] a, input logic [8:0] e);
        vec_t v;
        v.r = r; v.h = h; v.a = a; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got {nsel,dp,seg}=%h, expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, advance the model, compare both DUTs.
    task automatic step(input logic r, input logic h, input logic [7:0] a);
        rst  = r;
        hold = h;
        abus = a;
        @(posedge clk);
        if (r) begin
            p_a = 0; snap_a = 8'h00;
            p_b = 0; snap_b = 8'h00;
        end else if (!h) begin
            if (p_a == 0) snap_a = a;
            if (p_b == 0) snap_b = a;
            p_a = (p_a + 1) % (1 + 2 * S + 2 * G);
            p_b = (p_b + 1) % (1 + 2 * S + 2 * G0);
        end
        #1;
        check("model_gap2", {ns_a, dp_a, seg_a}, model_out(p_a, snap_a, G));
        check("model_gap0", {ns_b, dp_b, seg_b}, model_out(p_b, snap_b, G0));
    endtask

    initial begin
        dec_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        p_a = 0; p_b = 0; snap_a = 8'h00; snap_b = 8'h00;
        rst = 1'b1; hold = 1'b0; abus = 8'h00;

        // Reset then one full period of 0x3A on the gap-2 instance.
        tv[0]  = row(1'b1, 1'b0, 8'h3A, 9'h000);
        tv[1]  = row(1'b0, 1'b0, 8'h3A, 9'h1CF);
        tv[2]  = row(1'b0, 1'b0, 8'h3A, 9'h1CF);
        tv[3]  = row(1'b0, 1'b0, 8'h3A, 9'h1CF);
        tv[4]  = row(1'b0, 1'b0, 8'h3A, 9'h1CF);
        tv[5]  = row(1'b0, 1'b0, 8'h3A, 9'h000);
        tv[6]  = row(1'b0, 1'b0, 8'h3A, 9'h000);
        tv[7]  = row(1'b0, 1'b0, 8'h3A, 9'h077);
        tv[8]  = row(1'b0, 1'b0, 8'h3A, 9'h077);
        tv[9]  = row(1'b0, 1'b0, 8'h3A, 9'h077);
        tv[10] = row(1'b0, 1'b0, 8'h3A, 9'h077);
        tv[11] = row(1'b0, 1'b0, 8'h3A, 9'h000);
        tv[12] = row(1'b0, 1'b0, 8'h3A, 9'h000);
        tv[13] = row(1'b0, 1'b0, 8'h3A, 9'h000);
        tv[14] = row(1'b0, 1'b0, 8'h3A, 9'h1CF);
        tv[15] = row(1'b0, 1'b0, 8'h3A, 9'h1CF);

        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(tv[i].r, tv[i].h, tv[i].a);
            check("table_3A", {ns_a, dp_a, seg_a}, pol(tv[i].exp));
        end

        // Snapshot isolation: bus changes mid-period only show next period.
        step(1'b1, 1'b0, 8'h3A);
        for (int c = 1; c <= 21; c++) begin
            step(1'b0, 1'b0, (c < 2) ? 8'h3A : 8'hF0);
            if (c == 9)  check("isol_lo_still_A", {ns_a, dp_a, seg_a}, pol(9'h077));
            if (c == 14) check("isol_next_hi_F",  {ns_a, dp_a, seg_a}, pol(9'h1F1));
            if (c == 20) check("isol_next_lo_0",  {ns_a, dp_a, seg_a}, pol(9'h03F));
        end

        // Hold for 5 cycles inside SHOW_LO stretches the period to 18.
        step(1'b1, 1'b0, 8'h3A);
        for (int c = 1; c <= 19; c++) begin
            step(1'b0, (c >= 9 && c <= 13), 8'h3A);
            if (c == 13) check("hold_frozen_lo", {ns_a, dp_a, seg_a}, pol(9'h077));
            if (c == 15) check("hold_lo_last",   {ns_a, dp_a, seg_a}, pol(9'h077));
            if (c == 16) check("hold_gap2",      {ns_a, dp_a, seg_a}, pol(9'h000));
            if (c == 18) check("hold_capture",   {ns_a, dp_a, seg_a}, pol(9'h000));
            if (c == 19) check("hold_next_hi",   {ns_a, dp_a, seg_a}, pol(9'h1CF));
        end

        // Reset in the middle of SHOW_LO restarts and latches the current bus.
        step(1'b1, 1'b0, 8'h3A);
        for (int c = 1; c <= 8; c++) step(1'b0, 1'b0, 8'h3A);
        step(1'b1, 1'b0, 8'h96);
        check("midrst_blank", {ns_a, dp_a, seg_a}, pol(9'h000));
        step(1'b0, 1'b0, 8'h96);
        check("midrst_new_hi", {ns_a, dp_a, seg_a}, pol(9'h1EF));

        // Zero-gap instance: period of 9, no blank besides CAPTURE.
        step(1'b1, 1'b0, 8'h5C);
        for (int c = 1; c <= 10; c++) begin
            step(1'b0, 1'b0, 8'h5C);
            if (c == 1)  check("gap0_hi_first", {ns_b, dp_b, seg_b}, pol(9'h1ED));
            if (c == 4)  check("gap0_hi_last",  {ns_b, dp_b, seg_b}, pol(9'h1ED));
            if (c == 5)  check("gap0_lo_first", {ns_b, dp_b, seg_b}, pol(9'h039));
            if (c == 8)  check("gap0_lo_last",  {ns_b, dp_b, seg_b}, pol(9'h039));
            if (c == 9)  check("gap0_capture",  {ns_b, dp_b, seg_b}, pol(9'h000));
            if (c == 10) check("gap0_wrap_hi",  {ns_b, dp_b, seg_b}, pol(9'h1ED));
        end

        // Random bus values, hold and occasional reset against the model.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
